tpu_bus_master: RTL
===================

# tpu_bus_master

Bus initiator that drives the TPU's memory-mapped slave port through a complete matrix job. It pulls A rows, B rows and C preload words from a valid/ready source stream and writes them to the TPU address map. It then issues the start write, waits out the multiply, reads the C result back and emits it on a valid/ready result stream. It sits between the host-side DMA/FIFO logic and the TPU.

## Interface
- DIM, 8, matrix dimension
- BITS_AB, 8, A/B element width
- BITS_C, 16, C element width
- ADDRW, 16, bus address width
- DATAW, 64, bus data width; DIM*BITS_AB == DATAW and DIM*BITS_C == 2*DATAW are required
- WAIT_CYCLES, 3*DIM-1, idle cycles between the start write and the first result read

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request pulse; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last result word is accepted
- src_data  in  DATAW  load word
- src_valid  in  1  load word valid
- src_ready  out  1  load word accepted when src_valid && src_ready
- r_w  out  1  bus direction: 1 = write, 0 = read
- addr  out  ADDRW  bus address
- bus_wdata  out  DATAW  bus write data (the TPU's dataIn)
- bus_rdata  in  DATAW  bus read data (the TPU's dataOut), combinational on addr
- res_data  out  DATAW  result word
- res_valid  out  1  result word valid
- res_ready  in  1  result word consumed when res_valid && res_ready

## Operation
- Address map: A row i at 0x0100+8*i. B row i at 0x0200+8*i. C row i at 0x0300+16*i, low half (elements 0..3) at offset 0 and high half at offset 8. Start command is a write to 0x0400 (data don't-care, driven 0).
- Load order: DIM A words (rows 0..DIM-1), then DIM B words (rows 0..DIM-1), then 2*DIM C words (row 0 low, row 0 high, row 1 low, …).
- States: IDLE → LOAD_A → LOAD_B → LOAD_C → START → WAIT → RD → OUT → (RD | DONE) → IDLE.
- IDLE: start=1 moves to LOAD_A. start in any other state is ignored.
- LOAD_*:
  - src_ready=1.
  - On a handshake, the next cycle drives r_w=1, the computed addr, and bus_wdata=src_data, then advances the word counter.
  - With no handshake, the next cycle drives r_w=0, addr=0x0000 (idle).
  - Leave the state after its last word.
- START: one cycle of r_w=1, addr=0x0400.
- WAIT: r_w=0, addr=0x0000 for WAIT_CYCLES cycles. addr must never equal 0x0400 here.
- RD: r_w=0, addr=C word address. At cycle end, capture bus_rdata into res_data and set res_valid.
- OUT: hold res_valid and res_data until res_ready. Then go to RD for the next word, or to DONE after word 2*DIM-1.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Counters: a word counter of width clog2(2*DIM)+1 and a wait counter of width clog2(WAIT_CYCLES)+1, both cleared on every state entry.

## Timing
- Reset values: r_w=0, addr=0, bus_wdata=0, src_ready=0, res_valid=0, res_data=0, busy=0, done=0, state IDLE, counters 0.
- r_w, addr and bus_wdata are registered. A bus write appears exactly one cycle after its source handshake.
- src_ready is combinational from state and is high in every LOAD_* cycle, including the last word.
- Read throughput is at most one word per 2 cycles (RD, OUT). res_valid rises the cycle after RD.
- Minimum job latency with no stalls: 1 + 4*DIM + 1 + WAIT_CYCLES + 2*(2*DIM) + 1 cycles from start to done.
- Reset asserted mid-job aborts immediately: outputs take reset values, no further bus writes, and the partial job is discarded.
- Source stalls insert idle bus cycles and never re-issue or skip an address. Result stalls hold addr and r_w=0.

## Structure
- Shared package tpu_pkg:
  - TPU_A_BASE=16'h0100, TPU_B_BASE=16'h0200, TPU_C_BASE=16'h0300, TPU_START=16'h0400
  - state enum tpu_master_state_t
  - word-size localparams
- Single module. No sub-module is needed. Both counters are inline.

## Test plan
- Unstalled job, DIM=8, connected to the TPU: src supplies A=identity, B rows i = {8{i}}, C preload = 0. Required results: 16 words; row i low = {4{16'(i)}}, high the same. done occurs at cycle 1+32+1+23+32+1=90.
- Bus trace check: the write addresses are exactly 0x0100..0x0138 step 8, 0x0200..0x0238 step 8, 0x0300..0x0378 step 8, then 0x0400 once. There are no writes during WAIT, and reads cover 0x0300..0x0378.
- Source backpressure: deassert src_valid every other cycle. Required: same address sequence, idle cycles with r_w=0, addr=0, identical results.
- Result backpressure: hold res_ready=0 for 5 cycles on word 3. Required: res_data stable, addr held at 0x0318, no word lost or duplicated.
- Reset mid-LOAD_B (after 3 B words), then a fresh start. Required: all outputs at reset values while rst_n=0, and the full job restarts at 0x0100.
- start pulses during busy: ignored, so exactly one done and one 0x0400 write per job.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU address map, bus word geometry and bus-master state encoding.
package tpu_pkg;

  localparam logic [15:0] TPU_A_BASE = 16'h0100;
  localparam logic [15:0] TPU_B_BASE = 16'h0200;
  localparam logic [15:0] TPU_C_BASE = 16'h0300;
  localparam logic [15:0] TPU_START  = 16'h0400;

  localparam int unsigned TPU_WORD_BYTES  = 8;
  localparam int unsigned TPU_WORD_SHIFT  = 3;
  localparam int unsigned TPU_C_ROW_BYTES = 16;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD_A = 4'd1;
  localparam logic [3:0] S_LOAD_B = 4'd2;
  localparam logic [3:0] S_LOAD_C = 4'd3;
  localparam logic [3:0] S_START  = 4'd4;
  localparam logic [3:0] S_WAIT   = 4'd5;
  localparam logic [3:0] S_RD     = 4'd6;
  localparam logic [3:0] S_OUT    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE   = S_IDLE,
    ST_LOAD_A = S_LOAD_A,
    ST_LOAD_B = S_LOAD_B,
    ST_LOAD_C = S_LOAD_C,
    ST_START  = S_START,
    ST_WAIT   = S_WAIT,
    ST_RD     = S_RD,
    ST_OUT    = S_OUT,
    ST_DONE   = S_DONE
  } tpu_master_state_t;

endpackage

// File: rtl/tpu_bus_master.sv
// Drives one complete TPU matrix job over the memory-mapped slave port:
// load A/B/C from a stream, start, wait, read C back onto a result stream.
module tpu_bus_master
  import tpu_pkg::*;
#(
  parameter int unsigned DIM         = 8,
  parameter int unsigned BITS_AB     = 8,
  parameter int unsigned BITS_C      = 16,
  parameter int unsigned ADDRW       = 16,
  parameter int unsigned DATAW       = 64,
  parameter int unsigned WAIT_CYCLES = 3*DIM-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [DATAW-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             r_w,
  output logic [ADDRW-1:0] addr,
  output logic [DATAW-1:0] bus_wdata,
  input  logic [DATAW-1:0] bus_rdata,
  output logic [DATAW-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int unsigned WCW = $clog2(2*DIM) + 1;
  localparam int unsigned WTW = $clog2(WAIT_CYCLES) + 1;
  localparam bit CFG_OK = (DIM*BITS_AB == DATAW) && (DIM*BITS_C == 2*DATAW);

  if (!CFG_OK) begin : g_bad_cfg
    $error("tpu_bus_master: DIM/BITS_AB/BITS_C do not match DATAW");
  end

  tpu_master_state_t state, next_state;
  logic [WCW-1:0]   word_cnt, word_nxt;
  logic [WTW-1:0]   wait_cnt, wait_nxt;
  logic             src_hs, res_hs, phase_change;
  logic             r_w_nxt;
  logic [ADDRW-1:0] addr_nxt, load_base;
  logic [DATAW-1:0] wdata_nxt;

  assign src_ready = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_LOAD_C);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign src_hs    = src_valid && src_ready;
  assign res_hs    = res_valid && res_ready;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_LOAD_A;
      ST_LOAD_A: if (src_hs && word_cnt == WCW'(DIM-1)) next_state = ST_LOAD_B;
      ST_LOAD_B: if (src_hs && word_cnt == WCW'(DIM-1)) next_state = ST_LOAD_C;
      ST_LOAD_C: if (src_hs && word_cnt == WCW'(2*DIM-1)) next_state = ST_START;
      ST_START:  next_state = ST_WAIT;
      ST_WAIT:   if (wait_cnt == WTW'(WAIT_CYCLES-1)) next_state = ST_RD;
      ST_RD:     next_state = ST_OUT;
      ST_OUT:    if (res_hs) next_state = (word_cnt == WCW'(2*DIM-1)) ? ST_DONE : ST_RD;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // The RD/OUT pair is one phase: the word counter walks across it.
  assign phase_change = (next_state != state) &&
                        !((state == ST_RD)  && (next_state == ST_OUT)) &&
                        !((state == ST_OUT) && (next_state == ST_RD));

  always_comb begin
    word_nxt = word_cnt;
    wait_nxt = wait_cnt;
    if (src_hs || res_hs) word_nxt = word_cnt + 1'b1;
    if (state == ST_WAIT) wait_nxt = wait_cnt + 1'b1;
    if (phase_change) begin
      word_nxt = '0;
      wait_nxt = '0;
    end
  end

  always_comb begin
    case (state)
      ST_LOAD_A: load_base = ADDRW'(TPU_A_BASE);
      ST_LOAD_B: load_base = ADDRW'(TPU_B_BASE);
      default:   load_base = ADDRW'(TPU_C_BASE);
    endcase
  end

  // Bus fields are registered: a load handshake shows on the bus next cycle,
  // while RD addresses are set up on entry so bus_rdata is valid in RD.
  always_comb begin
    r_w_nxt   = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    if (src_hs) begin
      r_w_nxt   = 1'b1;
      addr_nxt  = load_base + (ADDRW'(word_cnt) << TPU_WORD_SHIFT);
      wdata_nxt = src_data;
    end else if (state == ST_START) begin
      r_w_nxt  = 1'b1;
      addr_nxt = ADDRW'(TPU_START);
    end
    if (next_state == ST_RD)
      addr_nxt = ADDRW'(TPU_C_BASE) + (ADDRW'(word_nxt) << TPU_WORD_SHIFT);
    else if (next_state == ST_OUT)
      addr_nxt = addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word_cnt  <= '0;
      wait_cnt  <= '0;
      r_w       <= 1'b0;
      addr      <= '0;
      bus_wdata <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= next_state;
      word_cnt  <= word_nxt;
      wait_cnt  <= wait_nxt;
      r_w       <= r_w_nxt;
      addr      <= addr_nxt;
      bus_wdata <= wdata_nxt;
      if (state == ST_RD) begin
        res_valid <= 1'b1;
        res_data  <= bus_rdata;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
